// File: rtl/program_loader.sv
// Byte-stream program loader: parses a 4-byte little-endian word-count header,
// forwards 4*N payload bytes to instruction memory, then answers ACK or NAK.
module program_loader #(
   parameter int         INST_MEM_WIDTH = 2,
   parameter logic [7:0] ACK_BYTE       = 8'hAA,
   parameter logic [7:0] NAK_BYTE       = 8'h55
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [7:0]  loader_data,
   output logic        loader_ready,
   output logic        loader_enable,
   output logic        load_done,
   output logic        load_error,
   output logic [31:0] word_count
);

   localparam int          CW        = INST_MEM_WIDTH + 2;
   localparam logic [31:0] MAX_WORDS = 32'd1 << INST_MEM_WIDTH;

   typedef enum logic [1:0] {HDR, LOAD, RESP, DONE} state_t;

   state_t         state_q, state_d;
   logic [1:0]     hdr_cnt_q, hdr_cnt_d;
   logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0]    word_count_q, word_count_d;
   logic [7:0]     loader_data_q, loader_data_d;
   logic           loader_ready_q, loader_ready_d;
   logic           loader_enable_q, loader_enable_d;
   logic [7:0]     tx_data_q, tx_data_d;
   logic           tx_valid_q, tx_valid_d;
   logic           load_done_q, load_done_d;
   logic           load_error_q, load_error_d;

   logic [31:0]    hdr_value;
   logic           hdr_last;
   logic           hdr_ok;
   logic [CW-1:0]  last_byte;
   logic           tx_fire;

   // The header check must include byte 3 as it arrives, so build the full value here.
   assign hdr_value = {rx_data, word_count_q[23:0]};
   assign hdr_last  = rx_valid && (hdr_cnt_q == 2'd3);
   assign hdr_ok    = (hdr_value != 32'd0) && (hdr_value <= MAX_WORDS);
   assign last_byte = {word_count_q[INST_MEM_WIDTH-1:0], 2'b00} - CW'(1);
   assign tx_fire   = tx_valid_q && tx_ready;

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q         <= HDR;
         hdr_cnt_q       <= '0;
         byte_cnt_q      <= '0;
         word_count_q    <= '0;
         loader_data_q   <= '0;
         loader_ready_q  <= 1'b0;
         loader_enable_q <= 1'b0;
         tx_data_q       <= '0;
         tx_valid_q      <= 1'b0;
         load_done_q     <= 1'b0;
         load_error_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         hdr_cnt_q       <= hdr_cnt_d;
         byte_cnt_q      <= byte_cnt_d;
         word_count_q    <= word_count_d;
         loader_data_q   <= loader_data_d;
         loader_ready_q  <= loader_ready_d;
         loader_enable_q <= loader_enable_d;
         tx_data_q       <= tx_data_d;
         tx_valid_q      <= tx_valid_d;
         load_done_q     <= load_done_d;
         load_error_q    <= load_error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HDR:     if (hdr_last) state_d = hdr_ok ? LOAD : RESP;
         LOAD:    if (rx_valid && (byte_cnt_q == last_byte)) state_d = RESP;
         RESP:    if (tx_fire) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = HDR;
      endcase
   end

   always_comb begin
      hdr_cnt_d      = hdr_cnt_q;
      byte_cnt_d     = byte_cnt_q;
      word_count_d   = word_count_q;
      loader_data_d  = loader_data_q;
      loader_ready_d = 1'b0;
      tx_data_d      = tx_data_q;
      tx_valid_d     = tx_valid_q;
      load_done_d    = load_done_q;
      load_error_d   = load_error_q;
      case (state_q)
         HDR: begin
            if (rx_valid) begin
               word_count_d[{hdr_cnt_q, 3'b000} +: 8] = rx_data;
               hdr_cnt_d = hdr_cnt_q + 2'd1;
               if (hdr_last && !hdr_ok) begin
                  load_error_d = 1'b1;
                  tx_data_d    = NAK_BYTE;
                  tx_valid_d   = 1'b1;
               end
            end
         end
         LOAD: begin
            if (rx_valid) begin
               loader_data_d  = rx_data;
               loader_ready_d = 1'b1;
               byte_cnt_d     = byte_cnt_q + CW'(1);
               if (byte_cnt_q == last_byte) begin
                  tx_data_d  = ACK_BYTE;
                  tx_valid_d = 1'b1;
               end
            end
         end
         RESP: begin
            if (tx_fire) begin
               tx_valid_d  = 1'b0;
               load_done_d = !load_error_q;
            end
         end
         default: ;
      endcase
      // Stay high through the cycle that carries the final payload strobe.
      loader_enable_d = (state_q == LOAD) || (state_d == LOAD);
   end

   assign tx_data       = tx_data_q;
   assign tx_valid      = tx_valid_q;
   assign loader_data   = loader_data_q;
   assign loader_ready  = loader_ready_q;
   assign loader_enable = loader_enable_q;
   assign load_done     = load_done_q;
   assign load_error    = load_error_q;
   assign word_count    = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed byte streams push expected
// loader and tx bytes into queues that a negedge monitor pops and checks.
module tb_program_loader;

   logic        CLK = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [7:0]  loader_data;
   logic        loader_ready;
   logic        loader_enable;
   logic        load_done;
   logic        load_error;
   logic [31:0] word_count;

   int total = 0;
   int bad = 0;
   int run_len = 0;
   int max_run = 0;

   logic [7:0] exp_load[$];
   logic [7:0] exp_tx[$];

   program_loader #(.INST_MEM_WIDTH(2), .ACK_BYTE(8'hAA), .NAK_BYTE(8'h55)) dut (
      .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .loader_data(loader_data), .loader_ready(loader_ready),
      .loader_enable(loader_enable), .load_done(load_done),
      .load_error(load_error), .word_count(word_count)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a strobe or a tx transfer.
   always @(negedge CLK) begin
      if (!reset) begin
         if (loader_ready) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_load.size() == 0) begin
               checkOutput("unexpected_loader_ready", {24'd0, loader_data}, 32'hFFFF_FFFF);
            end else begin
               checkOutput("loader_data", {24'd0, loader_data}, {24'd0, exp_load.pop_front()});
               checkOutput("enable_during_strobe", {31'd0, loader_enable}, 32'd1);
            end
         end else begin
            run_len = 0;
         end
         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0)
               checkOutput("unexpected_tx", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else
               checkOutput("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
         end
         checkOutput("done_error_exclusive", {31'd0, load_done && load_error}, 32'd0);
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge CLK);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      reset = 1'b0;
      idle(1);
   endtask

   task automatic check_idle_outputs(input string tag);
      checkOutput({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
      checkOutput({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      checkOutput({tag, "_loader_data"}, {24'd0, loader_data}, 32'd0);
      checkOutput({tag, "_loader_ready"}, {31'd0, loader_ready}, 32'd0);
      checkOutput({tag, "_loader_enable"}, {31'd0, loader_enable}, 32'd0);
      checkOutput({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
      checkOutput({tag, "_load_error"}, {31'd0, load_error}, 32'd0);
      checkOutput({tag, "_word_count"}, word_count, 32'd0);
   endtask

   task automatic nak_case(input string tag, input logic [7:0] h0, input logic [7:0] h3);
      do_reset();
      exp_tx.push_back(8'h55);
      applyStimulus(h0);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(h3);
      checkOutput({tag, "_enable_low"}, {31'd0, loader_enable}, 32'd0);
      checkOutput({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd1);
      idle(2);
      checkOutput({tag, "_load_error"}, {31'd0, load_error}, 32'd1);
      checkOutput({tag, "_load_done"}, {31'd0, load_done}, 32'd0);
      checkOutput({tag, "_tx_valid_after"}, {31'd0, tx_valid}, 32'd0);
      checkOutput({tag, "_enable_after"}, {31'd0, loader_enable}, 32'd0);
   endtask

   initial begin
      logic [7:0] payload[8];
      payload = '{8'h04, 8'h10, 8'hc2, 8'h00, 8'h58, 8'h04, 8'h65, 8'h00};

      $display("[TB] start");
      reset = 1'b1;
      #2;
      check_idle_outputs("async_reset");
      repeat (2) @(posedge CLK);
      #1;
      reset = 1'b0;
      idle(1);
      check_idle_outputs("after_reset");

      // Normal load, N=2
      applyStimulus(8'h02);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      checkOutput("normal_enable_before_hdr3", {31'd0, loader_enable}, 32'd0);
      applyStimulus(8'h00);
      checkOutput("normal_enable_rise", {31'd0, loader_enable}, 32'd1);
      checkOutput("normal_word_count", word_count, 32'd2);
      for (int i = 0; i < 8; i++) exp_load.push_back(payload[i]);
      exp_tx.push_back(8'hAA);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(payload[i]);
         idle(1);
      end
      checkOutput("normal_enable_fall", {31'd0, loader_enable}, 32'd0);
      idle(2);
      checkOutput("normal_load_done", {31'd0, load_done}, 32'd1);
      checkOutput("normal_load_error", {31'd0, load_error}, 32'd0);
      checkOutput("normal_word_count_final", word_count, 32'd2);
      checkOutput("normal_load_queue_empty", exp_load.size(), 32'd0);
      checkOutput("normal_tx_queue_empty", exp_tx.size(), 32'd0);

      // Last-byte timing: enable still high alongside final strobe, low right after
      do_reset();
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      exp_load.push_back(8'h01); exp_load.push_back(8'h02);
      exp_load.push_back(8'h03); exp_load.push_back(8'h04);
      exp_tx.push_back(8'hAA);
      applyStimulus(8'h01); idle(1);
      applyStimulus(8'h02); idle(1);
      applyStimulus(8'h03); idle(1);
      checkOutput("gap_enable_held", {31'd0, loader_enable}, 32'd1);
      applyStimulus(8'h04);
      checkOutput("final_strobe", {31'd0, loader_ready}, 32'd1);
      checkOutput("final_strobe_enable", {31'd0, loader_enable}, 32'd1);
      idle(1);
      checkOutput("final_enable_fall", {31'd0, loader_enable}, 32'd0);
      idle(2);
      checkOutput("n1_load_done", {31'd0, load_done}, 32'd1);

      nak_case("zero", 8'h00, 8'h00);
      nak_case("oversize", 8'h05, 8'h00);
      nak_case("oversize_b3", 8'h01, 8'h01);
      checkOutput("oversize_b3_word_count", word_count, 32'h0100_0001);

      // Reset mid-load
      do_reset();
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      exp_load.push_back(8'h11); exp_load.push_back(8'h22); exp_load.push_back(8'h33);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      idle(1);
      reset = 1'b1;
      #1;
      check_idle_outputs("midload_reset");
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK);
         #1;
         checkOutput("midload_reset_enable", {31'd0, loader_enable}, 32'd0);
         checkOutput("midload_reset_ready", {31'd0, loader_ready}, 32'd0);
      end
      reset = 1'b0;
      idle(1);
      checkOutput("midload_queue_drained", exp_load.size(), 32'd0);
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      exp_load.push_back(8'haa); exp_load.push_back(8'hbb);
      exp_load.push_back(8'hcc); exp_load.push_back(8'hdd);
      exp_tx.push_back(8'hAA);
      applyStimulus(8'haa);
      applyStimulus(8'hbb);
      applyStimulus(8'hcc);
      applyStimulus(8'hdd);
      idle(3);
      checkOutput("reload_load_done", {31'd0, load_done}, 32'd1);
      checkOutput("reload_word_count", word_count, 32'd1);

      // Back-pressure, back-to-back payload, trailing bytes
      do_reset();
      tx_ready = 1'b0;
      applyStimulus(8'h01);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      exp_load.push_back(8'h5a); exp_load.push_back(8'ha5);
      exp_load.push_back(8'h3c); exp_load.push_back(8'hc3);
      max_run = 0;
      applyStimulus(8'h5a);
      applyStimulus(8'ha5);
      applyStimulus(8'h3c);
      applyStimulus(8'hc3);
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_tx_valid", {31'd0, tx_valid}, 32'd1);
         checkOutput("bp_tx_data", {24'd0, tx_data}, 32'h0000_00AA);
         idle(1);
      end
      checkOutput("bp_max_run", max_run, 32'd4);
      checkOutput("bp_not_done_yet", {31'd0, load_done}, 32'd0);
      exp_tx.push_back(8'hAA);
      tx_ready = 1'b1;
      idle(1);
      tx_ready = 1'b0;
      checkOutput("bp_tx_valid_fall", {31'd0, tx_valid}, 32'd0);
      checkOutput("bp_load_done", {31'd0, load_done}, 32'd1);
      tx_ready = 1'b1;
      applyStimulus(8'h77);
      applyStimulus(8'h88);
      applyStimulus(8'h99);
      idle(3);
      checkOutput("trail_tx_valid", {31'd0, tx_valid}, 32'd0);
      checkOutput("trail_enable", {31'd0, loader_enable}, 32'd0);
      checkOutput("trail_load_done", {31'd0, load_done}, 32'd1);
      checkOutput("trail_word_count", word_count, 32'd1);

      checkOutput("final_load_queue_empty", exp_load.size(), 32'd0);
      checkOutput("final_tx_queue_empty", exp_tx.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Producer side of the instruction-memory loader interface.
- Takes a byte stream from the UART receiver and parses a 4-byte little-endian word-count header.
- Forwards exactly 4*N payload bytes to inst_memory as loader_data/loader_ready strobes, framed by loader_enable.
- On completion, returns a one-byte ACK or NAK to the host through the UART transmitter handshake.

Parameters:
- INST_MEM_WIDTH, 2, log2 of instruction memory depth in words; maximum legal N = 2^INST_MEM_WIDTH.
- ACK_BYTE, 8'hAA, byte sent after a successful load.
- NAK_BYTE, 8'h55, byte sent when the header is rejected.

Ports:
- CLK  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_data  input  8  received UART byte
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
- tx_data  output  8  response byte to UART transmitter
- tx_valid  output  1  response byte pending
- tx_ready  input  1  transmitter accepts tx_data this cycle when tx_valid=1
- loader_data  output  8  byte to inst_memory
- loader_ready  output  1  one-cycle strobe; loader_data valid
- loader_enable  output  1  high for the whole payload phase
- load_done  output  1  sticky; program loaded and ACK sent
- load_error  output  1  sticky; header rejected and NAK sent
- word_count  output  32  latched header value N

Behaviour:
- Reset: asynchronous, active-high; one clock (CLK).
  - Outputs on reset: tx_data=0, tx_valid=0, loader_data=0, loader_ready=0, loader_enable=0, load_done=0, load_error=0, word_count=0.
  - Internal counters cleared; state=HDR.
  - Reset asserted mid-operation aborts immediately. A partial load is abandoned; the next byte after reset release is treated as header byte 0.
- States: HDR, LOAD, RESP, DONE.
- HDR:
  - Each rx_valid shifts rx_data into word_count at byte position hdr_cnt (byte 0 = bits 7:0, little-endian); hdr_cnt then increments.
  - On the 4th byte, the full value N is checked (header byte 3 included):
    - 1 <= N <= 2^INST_MEM_WIDTH: next state LOAD. loader_enable rises the cycle after the 4th header byte is sampled.
    - Otherwise: load_error=1, tx_data=NAK_BYTE, next state RESP.
- LOAD:
  - Payload byte counter byte_cnt has width INST_MEM_WIDTH+2 and starts at 0.
  - Each rx_valid registers loader_data<=rx_data and loader_ready<=1 for exactly one cycle; the strobe lands one cycle after the rx_valid. byte_cnt increments.
  - rx_valid on consecutive cycles produces back-to-back loader_ready pulses; no byte is dropped.
  - When the accepted byte has byte_cnt = 4N-1:
    - loader_enable stays high in the cycle carrying that final loader_ready pulse, then falls.
    - tx_data=ACK_BYTE; next state RESP.
  - loader_enable never falls between bytes.
- RESP:
  - tx_valid=1 with tx_data held stable until a cycle where tx_ready=1. tx_valid falls the following cycle.
  - A cycle with tx_valid=1 and tx_ready=1 counts as the transfer.
  - On transfer: if load_error=0, set load_done=1. Next state DONE.
  - rx_valid is ignored in this state.
- DONE:
  - Terminal until reset. load_done/load_error hold their values; word_count holds N.
  - All further rx_valid bytes are ignored (no loader_ready, no tx); the UART stream then belongs to the CPU.
- loader_ready is never asserted outside LOAD, and never while loader_enable=0.
- load_done and load_error are never both 1.

Test Plan:
- Normal load, INST_MEM_WIDTH=2:
  - Stimulus: rx bytes 02 00 00 00 04 10 c2 00 58 04 65 00, tx_ready=1.
  - Response: 8 loader_ready pulses carrying 04,10,c2,00,58,04,65,00 in order; loader_enable high from the cycle after byte 4 through the 8th pulse, low the next cycle.
  - Then tx_data=AA for one accepted cycle; load_done=1, load_error=0, word_count=2.
- Zero length: header 00 00 00 00 -> no loader_ready and loader_enable stays 0; tx_data=55; load_error=1, load_done=0.
- Oversize: header 05 00 00 00 with INST_MEM_WIDTH=2 -> NAK 55; load_error=1.
- Oversize via byte 3: header 01 00 00 01 -> NAK 55; load_error=1.
- Reset mid-load:
  - Stimulus: header 01 00 00 00, payload 11 22 33, then assert reset 3 cycles.
  - Response: all outputs 0 during reset.
  - After release, sending 01 00 00 00 aa bb cc dd -> pulses aa,bb,cc,dd, then ACK, load_done=1.
- Back-pressure and trailing bytes:
  - Normal N=1 load with tx_ready held 0 for 10 cycles -> tx_valid=1, tx_data=AA stable all 10 cycles; single transfer when tx_ready=1.
  - Back-to-back rx_valid on 4 consecutive payload cycles -> 4 consecutive loader_ready pulses.
  - Extra rx bytes in DONE -> no loader_ready, no tx activity.
